cordic_phase_scheduler: RTL and testbench

- Time-shares one 12-bit atan CORDIC pipeline (x, y -> phase q) between NUM_CH IQ sample streams.
- Round-robin arbitration issues at most one sample per clock into the CORDIC.
- Each issued sample carries a tag (valid plus channel id) through a delay line matched to the CORDIC latency.
- Each returned phase is labelled with its channel, so downstream per-channel phase unwrap keeps separate state per stream.

---
 rtl/cordic_phase_scheduler.sv | 232 +++++++++++++++++++++++
 tb/tb_cordic_phase_scheduler.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_phase_scheduler.sv
// cordic_phase_scheduler
//
// Time-shares one atan CORDIC pipeline (x, y -> phase) between NUM_CH IQ sample
// streams. A round-robin arbiter grants at most one sample per clock. The granted
// sample is registered onto cordic_x_o/cordic_y_o. Its channel id travels down a
// tag delay line that is matched to the CORDIC latency, so each returned phase
// leaves labelled with the channel that produced it.
//
// Ports
//   clk_i        system clock
//   areset_i     asynchronous active-high reset
//   sched_en_i   1 = new grants allowed; 0 = stop granting, in-flight results drain
//   ch_valid_i   per-channel sample valid
//   ch_x_i       per-channel I sample, channel i at [i*DW +: DW]
//   ch_y_i       per-channel Q sample, same packing
//   ch_ready_o   one-hot grant (combinational)
//   cordic_x_o   registered x to the CORDIC
//   cordic_y_o   registered y to the CORDIC
//   cordic_q_i   phase result returned by the CORDIC
//   out_valid_o  single-cycle pulse per returned phase
//   out_ch_o     channel of out_phase_o
//   out_phase_o  phase result
//   busy_o       any tag in flight or output register valid
//
// Optional feature, macro CORDIC_SCHED_STATS_EN:
//   stats_clr_i  synchronous clear of the issue counters
//   stats_cnt_o  per-channel saturating 16-bit issue counters, channel i at [i*16 +: 16]

module cordic_phase_scheduler #(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned DW         = 12,
    parameter int unsigned CORDIC_LAT = 14,
    parameter int unsigned CHW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk_i,
    input  logic                 areset_i,
    input  logic                 sched_en_i,
    input  logic [NUM_CH-1:0]    ch_valid_i,
    input  logic [NUM_CH*DW-1:0] ch_x_i,
    input  logic [NUM_CH*DW-1:0] ch_y_i,
    output logic [NUM_CH-1:0]    ch_ready_o,
    output logic [DW-1:0]        cordic_x_o,
    output logic [DW-1:0]        cordic_y_o,
    input  logic [DW-1:0]        cordic_q_i,
    output logic                 out_valid_o,
    output logic [CHW-1:0]       out_ch_o,
    output logic [DW-1:0]        out_phase_o,
`ifdef CORDIC_SCHED_STATS_EN
    input  logic                 stats_clr_i,
    output logic [NUM_CH*16-1:0] stats_cnt_o,
`endif
    output logic                 busy_o
);

    // ------------------------------------------------------------------
    // Round-robin arbiter
    // ------------------------------------------------------------------
    logic [CHW-1:0] rr_q, rr_d;
    logic           grant_vld;
    logic [CHW-1:0] grant_id;
    logic [DW-1:0]  grant_x;
    logic [DW-1:0]  grant_y;

    // Two passes: channels above rr_q first, then wrap to channels 0..rr_q.
    // The first valid channel found wins, so this is a rotating priority search.
    always_comb begin
        grant_vld  = 1'b0;
        grant_id   = '0;
        grant_x    = '0;
        grant_y    = '0;
        ch_ready_o = '0;
        if (sched_en_i) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (!grant_vld && ch_valid_i[i] && (CHW'(i) > rr_q)) begin
                    grant_vld     = 1'b1;
                    grant_id      = CHW'(i);
                    grant_x       = ch_x_i[i*DW +: DW];
                    grant_y       = ch_y_i[i*DW +: DW];
                    ch_ready_o[i] = 1'b1;
                end
            end
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (!grant_vld && ch_valid_i[i] && (CHW'(i) <= rr_q)) begin
                    grant_vld     = 1'b1;
                    grant_id      = CHW'(i);
                    grant_x       = ch_x_i[i*DW +: DW];
                    grant_y       = ch_y_i[i*DW +: DW];
                    ch_ready_o[i] = 1'b1;
                end
            end
        end
    end

    // A grant is only ever raised on a valid channel, so grant_vld is the transfer.
    assign rr_d = grant_vld ? grant_id : rr_q;

    always_ff @(posedge clk_i or posedge areset_i) begin
        if (areset_i) begin
            rr_q <= CHW'(NUM_CH - 1);
        end else begin
            rr_q <= rr_d;
        end
    end

    // ------------------------------------------------------------------
    // Issue register
    // ------------------------------------------------------------------
    logic [DW-1:0] cordic_x_q, cordic_x_d;
    logic [DW-1:0] cordic_y_q, cordic_y_d;

    // x/y hold when idle so the CORDIC input does not toggle needlessly.
    assign cordic_x_d = grant_vld ? grant_x : cordic_x_q;
    assign cordic_y_d = grant_vld ? grant_y : cordic_y_q;

    always_ff @(posedge clk_i or posedge areset_i) begin
        if (areset_i) begin
            cordic_x_q <= '0;
            cordic_y_q <= '0;
        end else begin
            cordic_x_q <= cordic_x_d;
            cordic_y_q <= cordic_y_d;
        end
    end

    assign cordic_x_o = cordic_x_q;
    assign cordic_y_o = cordic_y_q;

    // ------------------------------------------------------------------
    // Tag delay line
    // Stage 0 is loaded alongside cordic_x/cordic_y. CORDIC_LAT further stages
    // bring the tag to index CORDIC_LAT in the same cycle as the matching cordic_q_i.
    // ------------------------------------------------------------------
    logic           tag_vld_q [CORDIC_LAT+1];
    logic [CHW-1:0] tag_id_q  [CORDIC_LAT+1];

    always_ff @(posedge clk_i or posedge areset_i) begin
        if (areset_i) begin
            for (int k = 0; k <= int'(CORDIC_LAT); k++) begin
                tag_vld_q[k] <= 1'b0;
                tag_id_q[k]  <= '0;
            end
        end else begin
            tag_vld_q[0] <= grant_vld;
            tag_id_q[0]  <= grant_id;
            for (int k = 1; k <= int'(CORDIC_LAT); k++) begin
                tag_vld_q[k] <= tag_vld_q[k-1];
                tag_id_q[k]  <= tag_id_q[k-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    logic           out_valid_q, out_valid_d;
    logic [CHW-1:0] out_ch_q, out_ch_d;
    logic [DW-1:0]  out_phase_q, out_phase_d;

    always_comb begin
        out_valid_d = tag_vld_q[CORDIC_LAT];
        out_ch_d    = out_ch_q;
        out_phase_d = out_phase_q;
        if (tag_vld_q[CORDIC_LAT]) begin
            out_ch_d    = tag_id_q[CORDIC_LAT];
            out_phase_d = cordic_q_i;
        end
    end

    always_ff @(posedge clk_i or posedge areset_i) begin
        if (areset_i) begin
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_phase_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_phase_q <= out_phase_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_ch_o    = out_ch_q;
    assign out_phase_o = out_phase_q;

    // Busy covers every sample from issue until its result has been presented.
    always_comb begin
        busy_o = out_valid_q;
        for (int k = 0; k <= int'(CORDIC_LAT); k++) begin
            busy_o = busy_o | tag_vld_q[k];
        end
    end

`ifdef CORDIC_SCHED_STATS_EN
    // ------------------------------------------------------------------
    // Per-channel saturating issue counters
    // ------------------------------------------------------------------
    logic [15:0] stats_q [NUM_CH];
    logic [15:0] stats_d [NUM_CH];

    // A clear wins over a transfer in the same cycle.
    always_comb begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
            stats_d[i] = stats_q[i];
            if (stats_clr_i) begin
                stats_d[i] = '0;
            end else if (grant_vld && (grant_id == CHW'(i)) && (stats_q[i] != 16'hFFFF)) begin
                stats_d[i] = stats_q[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge areset_i) begin
        if (areset_i) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                stats_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                stats_q[i] <= stats_d[i];
            end
        end
    end

    always_comb begin
        stats_cnt_o = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            stats_cnt_o[i*16 +: 16] = stats_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_cordic_phase_scheduler.sv
// Self-checking bench for cordic_phase_scheduler (NUM_CH=2, DW=12, CORDIC_LAT=14).
// A behavioural CORDIC (atan2 delayed by CORDIC_LAT clocks) sits on the cordic ports.
// A reference model predicts grants and the expected result stream: rotating
// priority, plus a queue of results each due 16 cycles after its handshake.

module tb_cordic_phase_scheduler;

    localparam int NUM_CH = 2;
    localparam int DW     = 12;
    localparam int LAT    = 14;
    localparam int CHW    = 1;

    logic                 clk = 1'b0;
    logic                 areset;
    logic                 sched_en;
    logic [NUM_CH-1:0]    ch_valid;
    logic [NUM_CH*DW-1:0] ch_x;
    logic [NUM_CH*DW-1:0] ch_y;
    logic [NUM_CH-1:0]    ch_ready;
    logic [DW-1:0]        cordic_x;
    logic [DW-1:0]        cordic_y;
    logic [DW-1:0]        cordic_q;
    logic                 out_valid;
    logic [CHW-1:0]       out_ch;
    logic [DW-1:0]        out_phase;
    logic                 busy;
`ifdef CORDIC_SCHED_STATS_EN
    logic                 stats_clr;
    logic [NUM_CH*16-1:0] stats_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cordic_phase_scheduler #(
        .NUM_CH     (NUM_CH),
        .DW         (DW),
        .CORDIC_LAT (LAT)
    ) dut (
        .clk_i       (clk),
        .areset_i    (areset),
        .sched_en_i  (sched_en),
        .ch_valid_i  (ch_valid),
        .ch_x_i      (ch_x),
        .ch_y_i      (ch_y),
        .ch_ready_o  (ch_ready),
        .cordic_x_o  (cordic_x),
        .cordic_y_o  (cordic_y),
        .cordic_q_i  (cordic_q),
        .out_valid_o (out_valid),
        .out_ch_o    (out_ch),
        .out_phase_o (out_phase),
`ifdef CORDIC_SCHED_STATS_EN
        .stats_clr_i (stats_clr),
        .stats_cnt_o (stats_cnt),
`endif
        .busy_o      (busy)
    );

    // Signed atan2 scaled so that +/-pi maps to +/-2048.
    function automatic logic [11:0] ref_atan(input logic [11:0] x, input logic [11:0] y);
        real a;
        int  v;
        a = $atan2($itor($signed(y)), $itor($signed(x)));
        v = $rtoi(a * 2048.0 / 3.141592653589793);
        if (v > 2047) v = 2047;
        return v[11:0];
    endfunction

    // Behavioural CORDIC: result for x/y presented in cycle c appears in cycle c+LAT.
    logic [DW-1:0] cpipe [LAT];
    always @(posedge clk) begin
        cpipe[0] <= ref_atan(cordic_x, cordic_y);
        for (int i = 1; i < LAT; i++) cpipe[i] <= cpipe[i-1];
    end
    assign cordic_q = cpipe[LAT-1];

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        int          ch;
        logic [11:0] ph;
    } exp_t;

    exp_t              q[$];
    int                m_rr;
    logic [NUM_CH-1:0] exp_ready;
    logic              exp_ov;
    logic [CHW-1:0]    exp_och;
    logic [DW-1:0]     exp_oph;
    logic              exp_busy;
    logic [DW-1:0]     exp_cx, exp_cy, nxt_cx, nxt_cy;

    task automatic model_reset();
        m_rr    = NUM_CH - 1;
        q.delete();
        exp_ov  = 1'b0;
        exp_och = '0;
        exp_oph = '0;
        nxt_cx  = '0;
        nxt_cy  = '0;
    endtask

    // Wait for the sampling point of the current cycle and compute the expected outputs.
    task automatic eval();
        int g;
        @(negedge clk);
        exp_cx = nxt_cx;
        exp_cy = nxt_cy;
        exp_ov = 1'b0;
        if (q.size() > 0 && q[0].due == cyc) begin
            exp_ov  = 1'b1;
            exp_och = CHW'(q[0].ch);
            exp_oph = q[0].ph;
            void'(q.pop_front());
        end
        exp_busy  = exp_ov || (q.size() > 0);
        exp_ready = '0;
        g = -1;
        if (sched_en) begin
            for (int k = 1; k <= NUM_CH; k++) begin
                int idx;
                idx = (m_rr + k) % NUM_CH;
                if (g < 0 && ch_valid[idx]) g = idx;
            end
        end
        if (g >= 0) begin
            exp_t e;
            exp_ready[g] = 1'b1;
            e.due  = cyc + LAT + 2;
            e.ch   = g;
            e.ph   = ref_atan(ch_x[g*DW +: DW], ch_y[g*DW +: DW]);
            q.push_back(e);
            nxt_cx = ch_x[g*DW +: DW];
            nxt_cy = ch_y[g*DW +: DW];
            m_rr   = g;
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        areset   = 1'b1;
        ch_valid = '0;
        next();
        areset = 1'b0;
        model_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        areset   = 1'b1;
        sched_en = 1'b0;
        ch_valid = '0;
        ch_x     = '0;
        ch_y     = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: out_valid=%b busy=%b want 0 0", out_valid, busy);
        end
        total++;
        if (cordic_x !== '0 || cordic_y !== '0 || out_ch !== '0 || out_phase !== '0) begin
            bad++;
            $display("FAIL reset_regs: x=%h y=%h ch=%h ph=%h want all 0",
                     cordic_x, cordic_y, out_ch, out_phase);
        end
        areset = 1'b0;
        model_reset();
    endtask

    task automatic test_single();
        int hs = -1;
        int ov = -1;
        sched_en = 1'b1;
        ch_valid = 2'b01;
        ch_x     = {12'h0, 12'h100};
        ch_y     = {12'h0, 12'h080};
        eval();
        total++;
        if (ch_ready !== 2'b01) begin
            bad++;
            $display("FAIL single_ready: got %b want 01", ch_ready);
        end
        hs = cyc;
        next();
        ch_valid = '0;
        ch_x     = '0;
        ch_y     = '0;
        eval();
        total++;
        if (cordic_x !== 12'h100 || cordic_y !== 12'h080) begin
            bad++;
            $display("FAIL single_issue: x=%h y=%h want 100 080", cordic_x, cordic_y);
        end
        for (int i = 0; i < 20; i++) begin
            if (i > 0) eval();
            if (out_valid === 1'b1 && ov < 0) ov = cyc;
            total++;
            if (out_valid !== exp_ov || busy !== exp_busy) begin
                bad++;
                $display("FAIL single_flags: ov=%b busy=%b want %b %b", out_valid, busy, exp_ov,
                         exp_busy);
            end
            if (exp_ov) begin
                total++;
                if (out_ch !== 1'b0 || out_phase !== ref_atan(12'h100, 12'h080)) begin
                    bad++;
                    $display("FAIL single_result: ch=%h ph=%h want 0 %h", out_ch, out_phase,
                             ref_atan(12'h100, 12'h080));
                end
            end
            next();
        end
        total++;
        if (ov - hs != 16) begin
            bad++;
            $display("FAIL single_latency: got %0d want 16", ov - hs);
        end
    endtask

    task automatic test_both_valid();
        int nres = 0;
        apply_reset();
        sched_en = 1'b1;
        for (int i = 0; i < 28; i++) begin
            ch_valid = (i < 8) ? 2'b11 : 2'b00;
            ch_x     = 24'($urandom);
            ch_y     = 24'($urandom);
            eval();
            if (i < 8) begin
                total++;
                if (ch_ready !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
                    bad++;
                    $display("FAIL both_grant[%0d]: got %b", i, ch_ready);
                end
            end
            total++;
            if (out_valid !== exp_ov || busy !== exp_busy) begin
                bad++;
                $display("FAIL both_flags: ov=%b busy=%b want %b %b", out_valid, busy, exp_ov,
                         exp_busy);
            end
            if (exp_ov) begin
                total++;
                if (out_ch !== CHW'(nres % 2) || out_phase !== exp_oph) begin
                    bad++;
                    $display("FAIL both_result[%0d]: ch=%h ph=%h want %h %h", nres, out_ch,
                             out_phase, nres % 2, exp_oph);
                end
                nres++;
            end
            next();
        end
        total++;
        if (nres != 8) begin
            bad++;
            $display("FAIL both_count: got %0d want 8", nres);
        end
    endtask

    task automatic test_ch1_then_ch0();
        apply_reset();
        sched_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ch_valid = (i < 3) ? 2'b10 : 2'b11;
            ch_x     = 24'($urandom);
            ch_y     = 24'($urandom);
            eval();
            total++;
            if (ch_ready !== ((i < 3) ? 2'b10 : 2'b01)) begin
                bad++;
                $display("FAIL ch1_then_ch0[%0d]: got %b", i, ch_ready);
            end
            next();
        end
        ch_valid = '0;
        for (int i = 0; i < 20; i++) begin
            eval();
            total++;
            if (out_valid !== exp_ov || (exp_ov && (out_ch !== exp_och || out_phase !== exp_oph)))
            begin
                bad++;
                $display("FAIL ch1_then_ch0_out: ov=%b ch=%h ph=%h want %b %h %h", out_valid,
                         out_ch, out_phase, exp_ov, exp_och, exp_oph);
            end
            next();
        end
    endtask

    task automatic test_sched_en();
        int nres = 0;
        apply_reset();
        for (int i = 0; i < 28; i++) begin
            sched_en = (i < 4);
            ch_valid = 2'b11;
            ch_x     = 24'($urandom);
            ch_y     = 24'($urandom);
            eval();
            if (i >= 4) begin
                total++;
                if (ch_ready !== 2'b00) begin
                    bad++;
                    $display("FAIL sched_off_ready: got %b want 00", ch_ready);
                end
            end
            total++;
            if (out_valid !== exp_ov || busy !== exp_busy ||
                (exp_ov && (out_ch !== exp_och || out_phase !== exp_oph))) begin
                bad++;
                $display("FAIL sched_out: ov=%b busy=%b ch=%h ph=%h want %b %b %h %h", out_valid,
                         busy, out_ch, out_phase, exp_ov, exp_busy, exp_och, exp_oph);
            end
            if (out_valid === 1'b1) nres++;
            next();
        end
        total++;
        if (nres != 4 || busy !== 1'b0) begin
            bad++;
            $display("FAIL sched_drain: results=%0d busy=%b want 4 0", nres, busy);
        end
        ch_valid = '0;
    endtask

    task automatic test_areset_midflight();
        apply_reset();
        sched_en = 1'b1;
        for (int i = 0; i < 11; i++) begin
            ch_valid = (i < 6) ? 2'b11 : 2'b00;
            ch_x     = 24'($urandom);
            ch_y     = 24'($urandom);
            eval();
            total++;
            if (ch_ready !== exp_ready || busy !== exp_busy) begin
                bad++;
                $display("FAIL arst_pre: ready=%b busy=%b want %b %b", ch_ready, busy, exp_ready,
                         exp_busy);
            end
            next();
        end
        areset = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL arst_immediate: ov=%b busy=%b want 0 0", out_valid, busy);
        end
        next();
        next();
        areset = 1'b0;
        model_reset();
        for (int i = 0; i < 26; i++) begin
            ch_valid = (i == 25) ? 2'b11 : 2'b00;
            eval();
            total++;
            if (out_valid !== exp_ov || busy !== exp_busy) begin
                bad++;
                $display("FAIL arst_after: ov=%b busy=%b want %b %b", out_valid, busy, exp_ov,
                         exp_busy);
            end
            if (i == 25) begin
                total++;
                if (ch_ready !== 2'b01) begin
                    bad++;
                    $display("FAIL arst_first_grant: got %b want 01", ch_ready);
                end
            end
            next();
        end
        ch_valid = '0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 320; i++) begin
            sched_en = ($urandom_range(0, 9) < 8);
            ch_valid = (i < 300) ? NUM_CH'($urandom) : '0;
            ch_x     = 24'($urandom);
            ch_y     = 24'($urandom);
            eval();
            total++;
            if (ch_ready !== exp_ready || out_valid !== exp_ov || busy !== exp_busy ||
                cordic_x !== exp_cx || cordic_y !== exp_cy) begin
                bad++;
                $display("FAIL rand_ctl[%0d]: rdy=%b ov=%b busy=%b x=%h y=%h want %b %b %b %h %h",
                         i, ch_ready, out_valid, busy, cordic_x, cordic_y, exp_ready, exp_ov,
                         exp_busy, exp_cx, exp_cy);
            end
            if (exp_ov) begin
                total++;
                if (out_ch !== exp_och || out_phase !== exp_oph) begin
                    bad++;
                    $display("FAIL rand_result[%0d]: ch=%h ph=%h want %h %h", i, out_ch,
                             out_phase, exp_och, exp_oph);
                end
            end
            next();
        end
    endtask

`ifdef CORDIC_SCHED_STATS_EN
    task automatic test_stats();
        apply_reset();
        stats_clr = 1'b0;
        sched_en  = 1'b1;
        ch_valid  = 2'b01;
        repeat (70000) @(posedge clk);
        #1;
        ch_valid = '0;
        total++;
        if (stats_cnt[15:0] !== 16'hFFFF || stats_cnt[31:16] !== 16'h0000) begin
            bad++;
            $display("FAIL stats_sat: got %h want ffff/0000", stats_cnt);
        end
        stats_clr = 1'b1;
        ch_valid  = 2'b01;
        next();
        stats_clr = 1'b0;
        ch_valid  = '0;
        total++;
        if (stats_cnt !== '0) begin
            bad++;
            $display("FAIL stats_clr: got %h want 0", stats_cnt);
        end
    endtask
`endif

    initial begin
        areset   = 1'b1;
        sched_en = 1'b0;
        ch_valid = '0;
        ch_x     = '0;
        ch_y     = '0;
`ifdef CORDIC_SCHED_STATS_EN
        stats_clr = 1'b0;
`endif
        model_reset();
        test_reset();
        next();
        test_single();
        test_both_valid();
        test_ch1_then_ch0();
        test_sched_en();
        test_areset_midflight();
        test_random();
`ifdef CORDIC_SCHED_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
